// File: rtl/bram_stream_reader_pkg.sv
// bram_stream_reader_pkg: shared buffer geometry, reader state encoding and pointer width rule
package bram_stream_reader_pkg;

    localparam int BUF_ADDR_WIDTH = 11;
    localparam int BUF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRIME  = 2'd1,
        STREAM = 2'd2
    } state_t;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: drains the dual-port byte buffer into a registered valid/ready stream after prefill
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH  = BUF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = BUF_DATA_WIDTH,
    parameter int PRIME_LEVEL = 1024,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    input  logic [ADDR_WIDTH:0]    wr_ptr,
    output logic [ADDR_WIDTH:0]    rd_ptr,
    output logic [ADDR_WIDTH-1:0]  dpra,
    input  logic [DATA_WIDTH-1:0]  dpo,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_WIDTH:0]    level,
    output logic                   streaming,
    output logic [COUNT_WIDTH-1:0] underrun_count,
    output logic                   overflow
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH     = PW'(1) << ADDR_WIDTH;
    localparam logic [PW-1:0] PRIME_THR = PW'(PRIME_LEVEL);

    state_t                 state_q, state_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic [COUNT_WIDTH-1:0] underrun_q, underrun_d;
    logic                   overflow_q, overflow_d;
    logic                   take;
    logic                   fetch;

    assign level          = wr_ptr - rd_ptr_q;
    assign rd_ptr         = rd_ptr_q;
    assign dpra           = rd_ptr_q[ADDR_WIDTH-1:0];
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign streaming      = state_q == STREAM;
    assign underrun_count = underrun_q;
    assign overflow       = overflow_q;

    always_comb begin
        take        = !out_valid_q || out_ready;
        fetch       = 1'b0;
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        underrun_d  = underrun_q;
        overflow_d  = overflow_q || (level > DEPTH);
        case (state_q)
            IDLE:    state_d = enable ? PRIME : IDLE;
            PRIME:   state_d = !enable ? IDLE : (level >= PRIME_THR) ? STREAM : PRIME;
            STREAM: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (take && level == '0) begin
                    state_d    = PRIME;
                    underrun_d = &underrun_q ? underrun_q : underrun_q + COUNT_WIDTH'(1);
                end else begin
                    fetch = take;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fetch) begin
            out_data_d  = dpo;
            out_valid_d = 1'b1;
            rd_ptr_d    = rd_ptr_q + PW'(1);
        end
        if (flush) begin
            state_d     = enable ? PRIME : IDLE;
            rd_ptr_d    = wr_ptr;
            out_data_d  = out_data_q;
            out_valid_d = 1'b0;
            underrun_d  = underrun_q;
            overflow_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            underrun_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            underrun_q  <= underrun_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
- Read-side controller for the 2k x 8 dual-port playback/capture buffer.
- The writer fills the RAM through the write port and publishes its wrapped write pointer.
- This block drains bytes through the asynchronous read port (dpra/dpo) into a registered valid/ready byte stream toward the converter path.
- Returns its read pointer to the writer for full detection, and prefills to a threshold before streaming.

Parameters:
- ADDR_WIDTH, 11, RAM address width; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, byte width of RAM and stream.
- PRIME_LEVEL, 1024, occupancy required before leaving PRIME; legal range 1..2**ADDR_WIDTH.
- COUNT_WIDTH, 16, width of underrun counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run request; low parks the block in IDLE.
- flush  in  1  one-cycle pulse: discard all buffered data.
- wr_ptr  in  ADDR_WIDTH+1  writer pointer, MSB is wrap bit.
- rd_ptr  out  ADDR_WIDTH+1  reader pointer, MSB is wrap bit, to writer.
- dpra  out  ADDR_WIDTH  RAM read address, equals rd_ptr[ADDR_WIDTH-1:0] combinationally.
- dpo  in  DATA_WIDTH  RAM asynchronous read data.
- out_data  out  DATA_WIDTH  stream byte (registered).
- out_valid  out  1  stream byte valid (registered).
- out_ready  in  1  consumer accepts.
- level  out  ADDR_WIDTH+1  occupancy, wr_ptr - rd_ptr modulo 2**(ADDR_WIDTH+1).
- streaming  out  1  high in STREAM state.
- underrun_count  out  COUNT_WIDTH  saturating underrun event count.
- overflow  out  1  sticky: level exceeded depth.

Behaviour:
- Reset values:
  - rd_ptr=0, out_data=0, out_valid=0, state=IDLE, underrun_count=0, overflow=0.
  - streaming=0.
  - level is combinational from wr_ptr/rd_ptr.
- take = !out_valid || out_ready (output slot free this cycle).
- States IDLE, PRIME, STREAM:
  - IDLE: enable=1 -> PRIME.
  - PRIME: enable=0 -> IDLE; level >= PRIME_LEVEL -> STREAM; no fetches.
  - STREAM: enable=0 -> IDLE; take && level==0 -> PRIME and underrun_count++ (saturates at all-ones).
- Fetch, STREAM only: take && level!=0 -> out_data<=dpo, out_valid<=1, rd_ptr<=rd_ptr+1.
  - Latency: byte visible on out_data the cycle after its address is on dpra.
  - Sustained throughput 1 byte/clk.
- Handshake:
  - Byte transfers when out_valid && out_ready.
  - When out_valid=1 && out_ready=0, out_data and out_valid are held stable.
  - If out_valid && out_ready and no fetch, out_valid<=0.
  - A pending byte in IDLE/PRIME remains until accepted; no new fetch occurs.
- Underrun is counted at most once per STREAM entry; the transition to PRIME happens on the same edge.
- overflow:
  - Set when level > 2**ADDR_WIDTH.
  - Cleared only by reset or flush.
  - Fetching continues regardless.
- flush (priority over all else except reset):
  - rd_ptr<=wr_ptr, out_valid<=0, overflow<=0.
  - state<=PRIME if enable else IDLE.
  - underrun_count unchanged.
- Simultaneous flush and fetch: flush wins, no increment.
- Simultaneous transfer and fetch: new byte replaces old, no bubble.
- Wrap: pointers wrap naturally at 2**(ADDR_WIDTH+1); dpra wraps at depth.
- Full (level==depth) is legal and streams normally.
- Reset mid-stream: all state returns to reset values next edge regardless of out_ready.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=0, PRIME=1, STREAM=2).
  - Default ADDR_WIDTH/DATA_WIDTH for the buffer, so writer, RAM and reader agree.
  - Pointer-difference helper width rule (ADDR_WIDTH+1).
- No sub-module is natural. The RAM stays external, connected via dpra/dpo, and the bench instantiates the existing 2k x 8 RAM.

Test Plan:
- Prime: enable=1, writer loads 0x00..0x3FF (1024 bytes), out_ready=1 -> streaming rises on the edge after level hits 1024; out_data sequence 0x00,0x01,... one per clk; rd_ptr=1024 after drain.
- Backpressure: during stream, hold out_ready=0 for 5 cycles -> out_data/out_valid constant; rd_ptr frozen; resume yields the next byte with no loss or duplicate.
- Underrun: PRIME_LEVEL=4, write 4 bytes, out_ready=1 -> 4 bytes out; then state=PRIME, underrun_count=1, streaming=0; rewrite 4 bytes -> resumes, count stays 1 until the next drain.
- Wrap: preset pointers near 2046; write 6 bytes -> dpra 2046,2047,0,1,2,3; rd_ptr MSB toggles; data order preserved.
- Flush: mid-stream with level=100, pulse flush together with a fetch -> next cycle out_valid=0, rd_ptr=wr_ptr, level=0, state=PRIME, no rd_ptr increment.
- Overflow/reset: force wr_ptr=rd_ptr+2049 -> overflow=1, sticky; assert reset mid-transfer -> all outputs return to reset values next edge.
